// File: rtl/seqdect_sched.sv
// seqdect_sched: round-robin scheduler sharing one serial 101010 detector among N word requesters
// Ports: clk, rst (async active-low); req/data from requesters; gnt acceptance pulse;
//        done/done_id/match_cnt/hit/first_pos job result; ser_x/ser_rst out to detector, ser_z back.
module seqdect_sched #(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = 2,
  parameter int CW    = 5,
  parameter int PW    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] data,
  output logic [N-1:0]       gnt,
  output logic               done,
  output logic [IDW-1:0]     done_id,
  output logic [CW-1:0]      match_cnt,
  output logic               hit,
  output logic [PW-1:0]      first_pos,
  output logic               ser_x,
  output logic               ser_rst,
  input  logic               ser_z
);
  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, REPORT} state_t;
  localparam logic [PW-1:0] last = PW'(WIDTH - 1);
  state_t state, state_n;
  logic [WIDTH-1:0] word;
  logic [IDW-1:0] ptr, id, sel, idx;
  logic [CW-1:0] cnt, cnt_n;
  logic [PW-1:0] k, pos, pos_n;
  logic seen, seen_n, z_hit, found, end_shift;
  // search upward from ptr+1, wrapping at N-1 so non-power-of-two N works
  always_comb begin
    sel = ptr;
    idx = ptr;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = (idx == IDW'(N - 1)) ? '0 : idx + IDW'(1);
      if (!found && req[idx]) begin
        sel = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    end_shift = state == SHIFT && k == last;
    z_hit = state == SHIFT && ser_z;
    cnt_n = (z_hit && cnt != '1) ? cnt + CW'(1) : cnt;
    pos_n = (z_hit && !seen) ? k : pos;
    seen_n = seen | z_hit;
    state_n = state == IDLE  ? (found ? CLEAR : IDLE) :
              state == CLEAR ? SHIFT :
              state == SHIFT ? (k == last ? REPORT : SHIFT) : IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  // word is shifted left so its MSB is always the next bit to present on ser_x
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt <= '0;
      done <= 1'b0;
      done_id <= '0;
      match_cnt <= '0;
      hit <= 1'b0;
      first_pos <= '0;
      ser_x <= 1'b0;
      ser_rst <= 1'b0;
      word <= '0;
      id <= '0;
      ptr <= IDW'(N - 1);
      cnt <= '0;
      pos <= '0;
      k <= '0;
      seen <= 1'b0;
    end else begin
      gnt <= '0;
      done <= 1'b0;
      ser_rst <= 1'b0;
      if (state == IDLE && found) begin
        word <= WIDTH'(data >> (int'(sel) * WIDTH));
        id <= sel;
        ptr <= sel;
        gnt <= N'(1) << sel;
        ser_rst <= 1'b1;
        ser_x <= 1'b0;
      end
      if (state == CLEAR) begin
        ser_x <= word[WIDTH-1];
        word <= word << 1;
        cnt <= '0;
        pos <= '0;
        seen <= 1'b0;
        k <= '0;
      end
      if (state == SHIFT) begin
        ser_x <= (k == last) ? 1'b0 : word[WIDTH-1];
        word <= word << 1;
        cnt <= cnt_n;
        pos <= pos_n;
        seen <= seen_n;
        k <= k + PW'(1);
      end
      if (end_shift) begin
        done <= 1'b1;
        done_id <= id;
        match_cnt <= cnt_n;
        hit <= seen_n;
        first_pos <= pos_n;
      end
    end
  end
endmodule

// File: tb/tb_seqdect_sched.sv
// tb_seqdect_sched: table, corner-case and random checks of seqdect_sched with a modelled 101010 detector
module tb_seqdect_sched;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] req = '0;
  logic [63:0] data = '0;
  logic [3:0] gnt;
  logic done, hit, ser_x, ser_rst, ser_z;
  logic [1:0] done_id;
  logic [4:0] match_cnt;
  logic [3:0] first_pos;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  seqdect_sched dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .gnt(gnt), .done(done),
    .done_id(done_id), .match_cnt(match_cnt), .hit(hit), .first_pos(first_pos),
    .ser_x(ser_x), .ser_rst(ser_rst), .ser_z(ser_z)
  );
  // external overlapping 101010 detector: last five bits plus fill level, Mealy output
  logic [4:0] dh = '0;
  logic [2:0] dn = '0;
  always @(posedge clk)
    if (ser_rst) begin
      dh <= '0;
      dn <= '0;
    end else begin
      dh <= {dh[3:0], ser_x};
      dn <= (dn == 3'd5) ? dn : dn + 3'd1;
    end
  assign ser_z = (dn == 3'd5) && (dh == 5'b10101) && !ser_x;
  typedef struct {
    int ch;
    logic [15:0] w;
    int cnt;
    int pos;
    bit scr;
  } vec_t;
  vec_t tbl[9];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  function automatic int ref_cnt(input logic [15:0] w, output int pos);
    int n = 0;
    pos = 0;
    for (int k = 5; k < 16; k++)
      if (w[20-k -: 6] == 6'b101010) begin
        if (n == 0) pos = k;
        n++;
      end
    return n;
  endfunction
  function automatic logic [31:0] outs();
    return 32'({gnt, done, done_id, match_cnt, hit, first_pos, ser_x, ser_rst});
  endfunction
  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    rst = 1'b1;
    @(negedge clk);
  endtask
  task automatic wait_gnt(output int t);
    t = 0;
    @(negedge clk);
    while (gnt == '0 && t < 40) begin
      @(negedge clk);
      t++;
    end
  endtask
  task automatic job(input int ch, input logic [15:0] w, input int ecnt, input int epos, input bit scr);
    int t, nr;
    logic [15:0] seen;
    req[ch] = 1'b1;
    data[ch*16 +: 16] = w;
    wait_gnt(t);
    chk("gnt_latency", t, 0);
    chk("gnt_onehot", 32'(gnt), 32'(1) << ch);
    chk("clear_ser_x", 32'(ser_x), 0);
    req[ch] = 1'b0;
    nr = int'(ser_rst);
    seen = '0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) chk("gnt_pulse", 32'(gnt), 0);
      seen[15-k] = ser_x;
      nr += int'(ser_rst);
      if (scr) data[ch*16 +: 16] = 16'($urandom);
    end
    @(negedge clk);
    nr += int'(ser_rst);
    chk("done_latency", 32'(done), 1);
    chk("ser_x_order", 32'(seen), 32'(w));
    chk("ser_rst_count", nr, 1);
    chk("done_id", 32'(done_id), ch);
    chk("match_cnt", 32'(match_cnt), ecnt);
    chk("hit", 32'(hit), ecnt != 0);
    chk("first_pos", 32'(first_pos), epos);
    @(negedge clk);
    chk("done_pulse", 32'(done), 0);
  endtask
  initial begin
    int t, nd, p, c;
    logic [15:0] w;
    logic [15:0] rw[4];
    tbl[0] = '{0, 16'hAAAA, 6, 5, 1'b0};
    tbl[1] = '{2, 16'h002A, 1, 15, 1'b0};
    tbl[2] = '{1, 16'h0000, 0, 0, 1'b0};
    tbl[3] = '{0, 16'h000A, 0, 0, 1'b0};
    tbl[4] = '{0, 16'hA000, 0, 0, 1'b0};
    tbl[5] = '{3, 16'hC3A5, 0, 0, 1'b1};
    tbl[6] = '{1, 16'h5555, 5, 6, 1'b0};
    tbl[7] = '{2, 16'h2AAA, 5, 7, 1'b1};
    tbl[8] = '{3, 16'hFFFF, 0, 0, 1'b0};
    do_reset();
    for (int i = 0; i < 9; i++) job(tbl[i].ch, tbl[i].w, tbl[i].cnt, tbl[i].pos, tbl[i].scr);
    job(1, 16'hAAAA, 6, 5, 1'b0);
    req[1] = 1'b1;
    data[16 +: 16] = 16'hAAAA;
    wait_gnt(t);
    req[1] = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_mid_shift", outs(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      nd += int'(done);
    end
    chk("no_done_after_abort", nd, 0);
    job(3, 16'hAAAA, 6, 5, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rw[i] = 16'hAAAA ^ 16'($urandom & $urandom);
      data[i*16 +: 16] = rw[i];
    end
    req = 4'b1111;
    for (int j = 0; j < 6; j++) begin
      if (j == 4) req = 4'b1001;
      c = (j < 4) ? j : (j == 4 ? 0 : 3);
      wait_gnt(t);
      chk("rr_order", 32'(gnt), 32'(1) << c);
      req = req & ~gnt;
      t = 0;
      while (!done && t < 40) begin
        @(negedge clk);
        t++;
      end
      chk("rr_done_id", 32'(done_id), c);
      chk("rr_match_cnt", 32'(match_cnt), ref_cnt(rw[c], p));
    end
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      c = $urandom_range(0, 3);
      w = $urandom_range(0, 1) ? 16'($urandom) : 16'hAAAA ^ 16'($urandom & $urandom & $urandom);
      nd = ref_cnt(w, p);
      job(c, w, nd, p, 1'($urandom_range(0, 1)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seqdect_sched.md
Name: seqdect_sched

Overview:
- Shares one external serial "101010" pattern detector between N word-wide requesters.
- Arbitrates requesters round-robin, latches the granted word and clears the detector.
- Shifts the word into the detector MSB-first, one bit per clock, and counts detector hits.
- Returns match count, first-hit position and originating channel id with a one-cycle done pulse.
- Sits between the requesting datapath blocks and the serial detector instance.

Parameters:
N, 4, number of requester channels (2..8).
WIDTH, 16, bits per job word.
IDW, 2, channel id width, clog2(N).
CW, 5, match counter width, clog2(WIDTH+1).
PW, 4, first-hit position width, clog2(WIDTH).

Ports:
clk  input  1  system clock, all state on rising edge.
rst  input  1  asynchronous, active-low reset.
req  input  N  per-channel job request, level, held until matching gnt.
data  input  N*WIDTH  channel i word at data[i*WIDTH +: WIDTH]; sampled on acceptance.
gnt  output  N  one-hot, one-cycle acceptance pulse, registered.
done  output  1  one-cycle result-valid pulse.
done_id  output  IDW  channel of completed job, valid with done.
match_cnt  output  CW  number of detector hits during the job, valid with done.
hit  output  1  match_cnt != 0, valid with done.
first_pos  output  PW  bit index (0 = first bit shifted) of first hit; 0 when hit=0.
ser_x  output  1  serial bit to detector input, registered.
ser_rst  output  1  detector clear pulse, active-high, registered.
ser_z  input  1  detector output (Mealy, combinational on current state and ser_x).

Behaviour:
- Reset (rst=0, async):
  - state IDLE; gnt=0, done=0, done_id=0, match_cnt=0, hit=0, first_pos=0, ser_x=0, ser_rst=0.
  - Round-robin pointer = N-1, so channel 0 has priority first.
- Reset mid-job aborts the job silently; no done is issued.
- FSM states: IDLE, CLEAR, SHIFT, REPORT.
- IDLE:
  - On an edge with req!=0, pick the first set req searching upward (mod N) from pointer+1.
  - Latch its word and id; pointer := granted id.
  - Next cycle: gnt[id]=1 and state CLEAR.
  - req=0: remain in IDLE.
- CLEAR (exactly 1 cycle):
  - ser_rst=1, ser_x=0; forces the detector to its initial state so no overlap carries across jobs.
  - Internal count, hit and position cleared.
  - Next state SHIFT with bit index = 0 and ser_x = word[WIDTH-1].
- SHIFT (exactly WIDTH cycles):
  - ser_rst=0; ser_x holds word bit WIDTH-1-k during cycle k.
  - ser_z is sampled at the end of cycle k.
  - If ser_z=1: count += 1, saturating at 2^CW-1. If this is the first hit, first_pos := k.
  - After cycle k=WIDTH-1, go to REPORT.
- REPORT (1 cycle):
  - done=1 with done_id, match_cnt, hit, first_pos; ser_x=0.
  - Next state IDLE.
- Result outputs hold their values until the next REPORT; done, gnt and ser_rst are pulses only.
- Latency: req sampled at edge E.
  - gnt and CLEAR in cycle E+1.
  - SHIFT in cycles E+2..E+WIDTH+1.
  - done in cycle E+WIDTH+2.
  - Minimum one IDLE cycle between jobs; the next gnt arrives no earlier than cycle E+WIDTH+4.
- Requester handshake:
  - The requester must drop req in the cycle after gnt unless it has a new job.
  - req still high in the IDLE cycle is treated as a new request.
- req changes during CLEAR, SHIFT or REPORT are ignored; the latched word is immune to data changes.
- Simultaneous requests: exactly one gnt bit per acceptance; every persistently requesting channel is served within N jobs.

Test Plan:
- Single job, ch0 data=16'hAAAA -> gnt=4'b0001 one cycle; done 18 cycles after req sampled; match_cnt=6, hit=1, first_pos=5, done_id=0.
- ch2 data=16'h002A -> match_cnt=1, first_pos=15, done_id=2. ch1 data=16'h0000 -> match_cnt=0, hit=0, first_pos=0.
- Detector isolation: ch0 16'h000A, then ch0 16'hA000 -> second job match_cnt=0 (an uncleared detector would flag bit 1); ser_rst high exactly one cycle per job.
- Round-robin: req=4'b1111 held, each channel dropping req after its gnt -> grant order 0,1,2,3. Then req=4'b1001 with pointer=3 -> channel 0 granted before 3.
- Reset mid-SHIFT (rst low at cycle 7 of SHIFT) -> all outputs at reset values immediately, no done. After release, a new ch3 16'hAAAA job -> match_cnt=6.
- Check ser_x against the expected MSB-first bit order for 16'hC3A5 across all 16 SHIFT cycles; data changed during SHIFT -> result unaffected.
